// File: rtl/fetch_unit.sv
// Instruction-fetch front end: boot-loads program words into IM, then generates PCs
// and aligns IM's one-cycle registered read data into the IF/ID (pc, inst, valid) boundary.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          IM_DEPTH_LOG2 = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        boot_done,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        IM_enable,
  output logic        IM_write,
  output logic [31:0] IM_address,
  output logic [31:0] IM_in,
  input  logic [31:0] IM_out,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [IM_DEPTH_LOG2-1:0] ld_ptr_q, ld_ptr_d;
  logic [31:0]              pc_q, pc_d;
  logic [31:0]              req_pc_q, req_pc_d;
  logic                     req_valid_q, req_valid_d;
  logic                     if_valid_q, if_valid_d;
  logic [31:0]              if_pc_q, if_pc_d;
  logic [31:0]              if_inst_q, if_inst_d;
  logic                     ld_xfer;

  function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
    word_idx = {{(32-IM_DEPTH_LOG2){1'b0}}, byte_addr[IM_DEPTH_LOG2+1:2]};
  endfunction

  assign ld_xfer = (state_q == S_LOAD) && ld_valid && rst;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      ld_ptr_q    <= '0;
      pc_q        <= '0;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == S_LOAD && ld_xfer && ld_last) begin
      state_d = S_RUN;
    end
  end

  // Loader pointer and PC pipeline; priority redirect > stall > advance
  always_comb begin
    ld_ptr_d    = ld_ptr_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    if (state_q == S_LOAD) begin
      if (ld_xfer) begin
        ld_ptr_d = ld_ptr_q + {{(IM_DEPTH_LOG2-1){1'b0}}, 1'b1};
        if (ld_last) begin
          pc_d        = RESET_PC;
          req_valid_d = 1'b0;
        end
      end
    end else if (redirect) begin
      pc_d        = redirect_pc & ~32'h3;
      req_valid_d = 1'b0;
      if_valid_d  = 1'b0;
    end else if (!stall) begin
      pc_d        = pc_q + 32'd4;
      req_pc_d    = pc_q;
      req_valid_d = 1'b1;
      if_valid_d  = req_valid_q;
      if_pc_d     = req_pc_q;
      if_inst_d   = IM_out;
    end
  end

  // Outputs; a stall re-reads the pending word so IM_out still holds it on release
  always_comb begin
    ld_ready   = 1'b0;
    boot_done  = 1'b0;
    IM_enable  = 1'b0;
    IM_write   = 1'b0;
    IM_address = '0;
    IM_in      = '0;
    case (state_q)
      S_LOAD: begin
        ld_ready  = rst;
        IM_enable = ld_xfer;
        IM_write  = ld_xfer;
        if (ld_xfer) begin
          IM_address = {{(32-IM_DEPTH_LOG2){1'b0}}, ld_ptr_q};
          IM_in      = ld_data;
        end
      end
      S_RUN: begin
        boot_done  = 1'b1;
        IM_enable  = 1'b1;
        IM_address = (stall && !redirect) ? word_idx(req_pc_q) : word_idx(pc_q);
      end
      default: begin
        ld_ready = 1'b0;
      end
    endcase
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: loader, sequential fetch, stall, redirect,
// stall+redirect, mid-run reset and loader pointer wrap, against a registered-read IM model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DL       = 4;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        boot_done;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        IM_enable;
  logic        IM_write;
  logic [31:0] IM_address;
  logic [31:0] IM_in;
  logic [31:0] IM_out;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  fetch_unit #(.RESET_PC(RESET_PC), .IM_DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .boot_done(boot_done), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .IM_enable(IM_enable), .IM_write(IM_write), .IM_address(IM_address), .IM_in(IM_in),
    .IM_out(IM_out), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: registered read, read-old-data on write, known fill during reset
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'hA000_0000 + 32'(k);
      IM_out <= 32'h0;
    end else if (IM_enable) begin
      if (IM_write) mem[IM_address[3:0]] <= IM_in;
      IM_out <= mem[IM_address[3:0]];
    end
  end

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
  } row_t;

  row_t rows [17];
  row_t sb_q [$];
  row_t e;

  int passed = 0;
  int total  = 0;

  function automatic row_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] addr);
    row_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc;
    t.exp_valid = v; t.exp_pc = pc; t.exp_inst = inst; t.exp_addr = addr;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ld_ready"},   {31'b0, ld_ready},  32'h0);
    check({tag, "_boot_done"},  {31'b0, boot_done}, 32'h0);
    check({tag, "_IM_enable"},  {31'b0, IM_enable}, 32'h0);
    check({tag, "_IM_write"},   {31'b0, IM_write},  32'h0);
    check({tag, "_IM_address"}, IM_address,         32'h0);
    check({tag, "_IM_in"},      IM_in,              32'h0);
    check({tag, "_if_valid"},   {31'b0, if_valid},  32'h0);
    check({tag, "_if_pc"},      if_pc,              32'h0);
    check({tag, "_if_inst"},    if_inst,            32'h0);
  endtask

  logic [31:0] words [4];

  initial begin
    // Rows are cycles R, R+1, ... after the boot load
    rows[0]  = mk(0, 0, 32'h0, 0, 32'h0,  32'h0,         32'd0);
    rows[1]  = mk(0, 0, 32'h0, 0, 32'h0,  32'h0,         32'd1);
    rows[2]  = mk(0, 0, 32'h0, 1, 32'h0,  32'h11,        32'd2);
    rows[3]  = mk(1, 0, 32'h0, 1, 32'h4,  32'h22,        32'd2);
    rows[4]  = mk(1, 0, 32'h0, 1, 32'h4,  32'h22,        32'd2);
    rows[5]  = mk(1, 0, 32'h0, 1, 32'h4,  32'h22,        32'd2);
    rows[6]  = mk(0, 0, 32'h0, 1, 32'h4,  32'h22,        32'd3);
    rows[7]  = mk(0, 1, 32'h6, 1, 32'h8,  32'h33,        32'd4);
    rows[8]  = mk(0, 0, 32'h0, 0, 32'h0,  32'h0,         32'd1);
    rows[9]  = mk(0, 0, 32'h0, 0, 32'h0,  32'h0,         32'd2);
    rows[10] = mk(0, 0, 32'h0, 1, 32'h4,  32'h22,        32'd3);
    rows[11] = mk(0, 0, 32'h0, 1, 32'h8,  32'h33,        32'd4);
    rows[12] = mk(1, 1, 32'hC, 1, 32'hC,  32'h44,        32'd5);
    rows[13] = mk(0, 0, 32'h0, 0, 32'h0,  32'h0,         32'd3);
    rows[14] = mk(0, 0, 32'h0, 0, 32'h0,  32'h0,         32'd4);
    rows[15] = mk(0, 0, 32'h0, 1, 32'hC,  32'h44,        32'd5);
    rows[16] = mk(0, 0, 32'h0, 1, 32'h10, 32'hA000_0004, 32'd6);
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;

    rst = 1'b0; ld_valid = 1'b0; ld_data = 32'hDEAD_BEEF; ld_last = 1'b0;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    #12;
    check_all_zero("reset");
    $display("reset: outputs sampled while rst low");

    @(posedge clk); #1;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("idle_ld_ready",  {31'b0, ld_ready},  32'h1);
    check("idle_IM_enable", {31'b0, IM_enable}, 32'h0);
    check("idle_boot_done", {31'b0, boot_done}, 32'h0);

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      @(negedge clk);
      check($sformatf("load%0d_IM_write", i),   {31'b0, IM_write},  32'h1);
      check($sformatf("load%0d_IM_enable", i),  {31'b0, IM_enable}, 32'h1);
      check($sformatf("load%0d_IM_address", i), IM_address,         32'(i));
      check($sformatf("load%0d_IM_in", i),      IM_in,              words[i]);
      check($sformatf("load%0d_boot_done", i),  {31'b0, boot_done}, 32'h0);
      $display("load %0d: addr=%0d data=0x%08h", i, IM_address, IM_in);
    end

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      ld_valid = 1'b0; ld_last = 1'b0;
      stall = rows[i].stall; redirect = rows[i].redirect; redirect_pc = rows[i].rpc;
      sb_q.push_back(rows[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("row%0d_if_valid", i),   {31'b0, if_valid},  {31'b0, e.exp_valid});
      check($sformatf("row%0d_IM_address", i), IM_address,         e.exp_addr);
      check($sformatf("row%0d_boot_done", i),  {31'b0, boot_done}, 32'h1);
      check($sformatf("row%0d_ld_ready", i),   {31'b0, ld_ready},  32'h0);
      check($sformatf("row%0d_IM_write", i),   {31'b0, IM_write},  32'h0);
      check($sformatf("row%0d_IM_enable", i),  {31'b0, IM_enable}, 32'h1);
      if (e.exp_valid) begin
        check($sformatf("row%0d_if_pc", i),   if_pc,   e.exp_pc);
        check($sformatf("row%0d_if_inst", i), if_inst, e.exp_inst);
      end
      $display("run R+%0d: stall=%0b redirect=%0b valid=%0b pc=0x%08h inst=0x%08h addr=%0d",
               i, stall, redirect, if_valid, if_pc, if_inst, IM_address);
    end

    // Mid-run reset clears everything asynchronously
    @(posedge clk); #1;
    stall = 1'b0; redirect = 1'b0;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    $display("mid-run reset asserted");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("postrst_ld_ready",  {31'b0, ld_ready},  32'h1);
    check("postrst_boot_done", {31'b0, boot_done}, 32'h0);

    @(posedge clk); #1;
    ld_valid = 1'b1; ld_data = 32'h55; ld_last = 1'b1;
    @(negedge clk);
    check("reload_IM_write",   {31'b0, IM_write}, 32'h1);
    check("reload_IM_address", IM_address,        32'h0);
    check("reload_IM_in",      IM_in,             32'h55);
    $display("reload: addr=%0d data=0x%08h", IM_address, IM_in);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("reload_boot_done",  {31'b0, boot_done}, 32'h1);
    check("reload_IM_address_R", IM_address,       32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reload_if_valid", {31'b0, if_valid}, 32'h1);
    check("reload_if_pc",    if_pc,             RESET_PC);
    check("reload_if_inst",  if_inst,           32'h55);
    $display("reload fetch: valid=%0b pc=0x%08h inst=0x%08h", if_valid, if_pc, if_inst);

    // Loader pointer wrap; stall/redirect must be ignored while loading
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_data = 32'h100 + 32'(i); ld_last = (i == 16);
      redirect = 1'b1; redirect_pc = 32'h3C; stall = i[0];
      @(negedge clk);
      check($sformatf("wrap%0d_IM_address", i), IM_address,        32'(i % 16));
      check($sformatf("wrap%0d_IM_write", i),   {31'b0, IM_write}, 32'h1);
      $display("wrap load %0d: addr=%0d data=0x%08h", i, IM_address, IM_in);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0; redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("wrapR_IM_address", IM_address,         32'h0);
    check("wrapR_if_valid",   {31'b0, if_valid},  32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrapR1_if_valid",  {31'b0, if_valid},  32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrapR2_if_valid",  {31'b0, if_valid},  32'h1);
    check("wrapR2_if_pc",     if_pc,              32'h0);
    check("wrapR2_if_inst",   if_inst,            32'h110);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrapR3_if_pc",     if_pc,              32'h4);
    check("wrapR3_if_inst",   if_inst,            32'h101);
    $display("wrap fetch: pc=0x%08h inst=0x%08h", if_pc, if_inst);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the pipelined core, sitting directly upstream of the instruction memory `IM`. After reset it runs a boot loader that streams program words into `IM` through its write port. It then becomes the PC generator, issuing one word read per cycle and absorbing the memory's one-cycle registered read latency. It presents aligned (pc, instruction, valid) to the IF/ID boundary, and supports decode-side stalls and branch redirects.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000 — byte address of first fetched instruction.
- `IM_DEPTH_LOG2`, 16 — log2 of IM word count; the word index is `pc[IM_DEPTH_LOG2+1:2]`, zero-extended to 32 bits.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `ld_valid`  in  1  — loader word present; must be 0 while `rst` is low.
- `ld_data`  in  32  — program word.
- `ld_last`  in  1  — qualifies final loader word.
- `ld_ready`  out  1  — loader may transfer.
- `boot_done`  out  1  — 1 once in RUN.
- `stall`  in  1  — hold IF/ID and PC (from hazard unit).
- `redirect`  in  1  — taken branch/jump.
- `redirect_pc`  in  32  — target byte address.
- `IM_enable`  out  1  — to IM.
- `IM_write`  out  1  — to IM.
- `IM_address`  out  32  — IM word index.
- `IM_in`  out  32  — IM write data.
- `IM_out`  in  32  — IM registered read data.
- `if_valid`  out  1  — IF/ID entry valid.
- `if_pc`  out  32  — byte PC of `if_inst`.
- `if_inst`  out  32  — fetched instruction.

## Operation
- Two-state FSM: LOAD (reset state) and RUN. There is no return to LOAD except via `rst`.
- LOAD:
  - `ld_ready`=1.
  - A transfer occurs when `ld_valid`=1. On a transfer: `IM_enable`=`IM_write`=1, `IM_address`=`ld_ptr`, `IM_in`=`ld_data`, and `ld_ptr` increments.
  - `ld_ptr` wraps from 2^IM_DEPTH_LOG2−1 to 0.
  - When `ld_valid`=0: `IM_enable`=`IM_write`=0.
  - A transfer with `ld_last`=1 moves the FSM to RUN and loads `pc`=`RESET_PC`.
  - `stall` and `redirect` are ignored in LOAD.
- RUN:
  - `ld_ready`=0, `boot_done`=1, `IM_write`=0, `IM_in`=0, `IM_enable`=1 every cycle.
- RUN registers: `pc` (address issued this cycle), `req_pc` (address issued last cycle), `req_valid` (last issue not squashed).
- Address select: `IM_address` = word index of `req_pc` when `stall`=1 and `redirect`=0; otherwise word index of `pc`. This re-reads the pending word so `IM_out` still holds it when the stall releases.
- Per-edge update, priority redirect > stall > advance:
  - **redirect:** `pc`<=`{redirect_pc[31:2],2'b00}`; `req_valid`<=0; `if_valid`<=0; `if_pc` and `if_inst` hold.
  - **stall:** `pc`, `req_pc`, `req_valid`, `if_*` all hold.
  - **advance:** `pc`<=`pc`+4 (32-bit wrap); `req_pc`<=`pc`; `req_valid`<=1; `if_valid`<=`req_valid`; `if_pc`<=`req_pc`; `if_inst`<=`IM_out`.
- On entry to RUN, `req_valid`=0, so the first `IM_out` is discarded.
- `if_*` is only meaningful when `if_valid`=1.

## Timing
- Reset values: FSM=LOAD; `ld_ptr`, `pc`, `req_pc`, `req_valid` = 0.
- Outputs while `rst` is low:
  - `ld_ready`=0 (gated by `rst`), `boot_done`=0.
  - `IM_enable`, `IM_write`, `IM_address`, `IM_in` = 0.
  - `if_valid`, `if_pc`, `if_inst` = 0.
- Load: one word per cycle. `IM_write` is combinational from `ld_valid`, so a word is written on the same edge it is accepted.
- First fetch: cycle R (first RUN cycle) issues `RESET_PC`. `if_valid`=1 with `if_pc`=`RESET_PC` is visible in cycle R+2.
- Steady state: one instruction per cycle, fetch-to-IF/ID latency 2 cycles.
- Redirect asserted in cycle t: `if_valid`=0 in t+1 and t+2; the target instruction is valid in t+3 (2-bubble penalty).
- Redirect and stall in the same cycle: the redirect wins, the in-flight fetch is squashed, and `if_valid`=0 next cycle.
- Stall for N cycles: IF/ID is frozen for N cycles. The next sequential instruction appears the cycle after the stall drops, with no loss or duplication.
- `rst` low at any time, including mid-load or mid-RUN: all state is cleared asynchronously; the program must be reloaded.

## Test plan
- Load 4 words 0x11,0x22,0x33,0x44 (`ld_last` on the 4th) -> IM writes to addresses 0..3 on consecutive edges; `boot_done`=1 the following cycle; `ld_ready`=0 afterwards.
- Sequential fetch after the above load with `RESET_PC`=0 -> `if_pc`/`if_inst` = 0/0x11, 4/0x22, 8/0x33, 12/0x44 on consecutive cycles, first valid at R+2.
- Stall held 3 cycles while `if_pc`=4 -> `if_pc`=4 holds 3 extra cycles, then 8/0x33 with no gap or repeat.
- Redirect to 0x0000_0006 while `if_pc`=8 -> two `if_valid`=0 cycles, then `if_pc`=4 (alignment forced), followed by 8, 12.
- Stall and redirect to 0xC asserted together -> redirect taken; `if_valid`=0 for 2 cycles, then `if_pc`=0xC/0x44.
- `rst` low mid-RUN for 1 cycle -> all outputs 0 immediately, FSM in LOAD, `ld_ready`=1 after release; a reload of 1 word with `ld_last` writes address 0 again.
